// File: rtl/joypad_ctrl.sv
// Game Boy joypad controller: synchronizes and debounces the eight front-panel buttons,
// presents the active-low P1/JOYP register and pulses the joypad interrupt on any falling nibble bit.
module joypad_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] btn_raw,
   input  logic       reg_we,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic       irq_joypad,
   output logic [7:0] pressed_dbg
);

   localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][7:0] r_sync;
   logic [7:0]                  r_db;
   logic [7:0][15:0]            r_cnt;
   logic [1:0]                  r_sel;
   logic [3:0]                  r_nib_q;
   logic                        r_irq;

   logic [7:0] w_s;
   logic [3:0] w_dir_n;
   logic [3:0] w_btn_n;
   logic [3:0] w_nib;
   logic       w_unused_wdata;

   // Stage 0 captures the raw pins; the last stage feeds the debouncers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // Each bit must disagree with its debounced value for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_db  <= '0;
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (w_s[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_db[i]  <= w_s[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      w_dir_n = ~r_db[3:0];
      w_btn_n = ~r_db[7:4];
      w_nib   = (r_sel[0] ? 4'hF : w_dir_n) & (r_sel[1] ? 4'hF : w_btn_n);
   end

   // nib_q holds last cycle's nibble so any 1->0 transition, including one caused by a sel write, fires.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sel   <= 2'b11;
         r_nib_q <= 4'hF;
         r_irq   <= 1'b0;
      end else begin
         if (reg_we) begin
            r_sel <= reg_wdata[5:4];
         end
         r_nib_q <= w_nib;
         r_irq   <= |(r_nib_q & ~w_nib);
      end
   end

   assign w_unused_wdata = ^{reg_wdata[7:6], reg_wdata[3:0]};

   assign reg_rdata   = {2'b11, r_sel, w_nib};
   assign irq_joypad  = r_irq;
   assign pressed_dbg = r_db;

endmodule

// File: tb/tb_joypad_ctrl.sv
// Self-checking bench for joypad_ctrl with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Expected values are queued when stimulus is applied and compared when the DUT output is sampled.
module tb_joypad_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [7:0] btn_raw;
   logic       reg_we;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       irq_joypad;
   logic [7:0] pressed_dbg;

   int n_assert = 0;
   int n_fail   = 0;
   int irq_cnt  = 0;
   int irq_base = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   logic [1:0] mux_sel [4];
   logic [7:0] mux_exp [4];

   joypad_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES    (2)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .btn_raw    (btn_raw),
      .reg_we     (reg_we),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .irq_joypad (irq_joypad),
      .pressed_dbg(pressed_dbg)
   );

   // clock / reset
   always #5 Clk = ~Clk;

   // irq pulses counted mid-cycle, away from the active edge
   always @(negedge Clk) begin
      if (irq_joypad === 1'b1) irq_cnt++;
   end

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [7:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic sb_pop_check(input logic [7:0] obs);
      logic [7:0] e;
      string      t;
      if (exp_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL sb_underflow: got %h with no expected entry", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_eq(t, {8'h00, obs}, {8'h00, e});
      end
   endtask

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic write_sel(input logic [1:0] sel);
      reg_wdata = {2'b00, sel, 4'h0};
      reg_we    = 1'b1;
      tick(1);
      reg_we    = 1'b0;
      reg_wdata = 8'h00;
   endtask

   initial begin
      mux_sel[0] = 2'b01; mux_exp[0] = 8'hDE;
      mux_sel[1] = 2'b10; mux_exp[1] = 8'hEE;
      mux_sel[2] = 2'b00; mux_exp[2] = 8'hCE;
      mux_sel[3] = 2'b11; mux_exp[3] = 8'hFF;

      Reset_n   = 1'b0;
      btn_raw   = 8'hFF;
      reg_we    = 1'b0;
      reg_wdata = 8'h00;

      // reset with every button held
      tick(3);
      sb_push("rst_rdata", 8'hFF);   sb_pop_check(reg_rdata);
      sb_push("rst_pressed", 8'h00); sb_pop_check(pressed_dbg);
      check_eq("rst_irq", {15'd0, irq_joypad}, 16'd0);
      btn_raw = 8'h00;
      tick(1);
      Reset_n = 1'b1;
      tick(4);
      check_eq("post_rst_irq_cnt", 16'(irq_cnt), 16'd0);

      // glitch of 3 cycles on A with the button group selected
      write_sel(2'b01);
      sb_push("sel01_idle_rdata", 8'hDF); sb_pop_check(reg_rdata);
      irq_base = irq_cnt;
      btn_raw[4] = 1'b1;
      tick(3);
      btn_raw[4] = 1'b0;
      tick(10);
      sb_push("glitch_pressed", 8'h00); sb_pop_check(pressed_dbg);
      check_eq("glitch_irq", 16'(irq_cnt - irq_base), 16'd0);

      // clean press of Right with the direction group selected
      write_sel(2'b10);
      sb_push("sel10_idle_rdata", 8'hEF); sb_pop_check(reg_rdata);
      irq_base = irq_cnt;
      btn_raw[0] = 1'b1;
      tick(5);
      sb_push("db_edge5_pressed", 8'h00); sb_pop_check(pressed_dbg);
      tick(1);
      sb_push("db_edge6_pressed", 8'h01); sb_pop_check(pressed_dbg);
      sb_push("db_edge6_rdata", 8'hEE);   sb_pop_check(reg_rdata);
      check_eq("db_irq_early", {15'd0, irq_joypad}, 16'd0);
      tick(1);
      check_eq("db_irq_pulse", {15'd0, irq_joypad}, 16'd1);
      tick(1);
      check_eq("db_irq_end", {15'd0, irq_joypad}, 16'd0);
      check_eq("db_irq_cnt", 16'(irq_cnt - irq_base), 16'd1);

      // group multiplexing with A and Right held
      irq_base = irq_cnt;
      btn_raw[4] = 1'b1;
      tick(8);
      sb_push("mux_pressed", 8'h11); sb_pop_check(pressed_dbg);
      for (int k = 0; k < 4; k++) begin
         write_sel(mux_sel[k]);
         sb_push($sformatf("mux_rdata_sel%0d", k), mux_exp[k]);
         sb_pop_check(reg_rdata);
      end
      tick(2);
      check_eq("mux_no_irq", 16'(irq_cnt - irq_base), 16'd0);
      write_sel(2'b01);
      tick(2);
      sb_push("mux_sel01_rdata", 8'hDE); sb_pop_check(reg_rdata);
      check_eq("sel_write_irq", 16'(irq_cnt - irq_base), 16'd1);

      // release of Right
      write_sel(2'b10);
      tick(2);
      irq_base = irq_cnt;
      btn_raw[0] = 1'b0;
      tick(5);
      sb_push("rel_edge5_rdata", 8'hEE); sb_pop_check(reg_rdata);
      tick(1);
      sb_push("rel_edge6_rdata", 8'hEF);   sb_pop_check(reg_rdata);
      sb_push("rel_edge6_pressed", 8'h10); sb_pop_check(pressed_dbg);
      tick(4);
      check_eq("rel_no_irq", 16'(irq_cnt - irq_base), 16'd0);

      // reset two cycles into a debounce of B
      btn_raw = 8'h00;
      tick(10);
      sb_push("pre_rst_pressed", 8'h00); sb_pop_check(pressed_dbg);
      btn_raw[5] = 1'b1;
      tick(2);
      Reset_n = 1'b0;
      #1;
      sb_push("mid_rst_rdata", 8'hFF);   sb_pop_check(reg_rdata);
      sb_push("mid_rst_pressed", 8'h00); sb_pop_check(pressed_dbg);
      tick(2);
      Reset_n = 1'b1;
      tick(5);
      sb_push("rst_edge5_pressed", 8'h00); sb_pop_check(pressed_dbg);
      tick(1);
      sb_push("rst_edge6_pressed", 8'h20); sb_pop_check(pressed_dbg);

      check_eq("sb_drain", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
